// File: rtl/wb_gpio.sv
// Wishbone classic GPIO slave: per-bit direction, synchronised inputs, edge interrupts.
// Optional per-bit input debounce is built when GPIO_DEBOUNCE_EN is defined.
module wb_gpio #(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [2:0]       wb_adr_i,
    input  logic [15:0]      wb_dat_i,
    output logic [15:0]      wb_dat_o,
    output logic             wb_ack_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq_o
);

    typedef enum logic [2:0] {
        ADR_IN   = 3'd0,
        ADR_OUT  = 3'd1,
        ADR_DIR  = 3'd2,
        ADR_IE   = 3'd3,
        ADR_EDGE = 3'd4,
        ADR_STAT = 3'd5
    } reg_addr_e;

    localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] pin_val;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] out_q, dir_q, ie_q, edge_q, stat_q;
    logic [WIDTH-1:0] evt, w1c, wr_data;
    logic [2:0]       arm_cnt;
    logic             armed;
    logic             ack_q, irq_q;
    logic [15:0]      dat_q, rdata;
    logic             access, wr_en;
    reg_addr_e        addr;

    // NOTE: every clocked process uses non-blocking assignments so that all
    // flops sample pre-edge values; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] deb_cnt [WIDTH];
    logic [WIDTH-1:0] deb_q;

    // A bit moves only after sync disagrees with it for a full window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_q <= '0;
            for (int i = 0; i < WIDTH; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == deb_q[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_q[i]   <= sync[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign pin_val = deb_q;
`else
    assign pin_val = sync;
`endif

    // Edges stay masked until the synchroniser has flushed its reset zeros.
    assign armed = (arm_cnt == ARM_DONE);
    assign evt   = armed ? ((edge_q & pin_val & ~prev_q) | (~edge_q & ~pin_val & prev_q))
                         : '0;

    assign addr    = reg_addr_e'(wb_adr_i);
    assign access  = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_en   = access & wb_we_i;
    assign wr_data = wb_dat_i[WIDTH-1:0];
    assign w1c     = (wr_en && addr == ADR_STAT) ? wr_data : '0;

    always_comb begin
        rdata = '0;
        case (addr)
            ADR_IN:   rdata[WIDTH-1:0] = pin_val;
            ADR_OUT:  rdata[WIDTH-1:0] = out_q;
            ADR_DIR:  rdata[WIDTH-1:0] = dir_q;
            ADR_IE:   rdata[WIDTH-1:0] = ie_q;
            ADR_EDGE: rdata[WIDTH-1:0] = edge_q;
            ADR_STAT: rdata[WIDTH-1:0] = stat_q;
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm_cnt <= '0;
            prev_q  <= '0;
            out_q   <= '0;
            dir_q   <= '0;
            ie_q    <= '0;
            edge_q  <= '0;
            stat_q  <= '0;
            irq_q   <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            if (!armed) arm_cnt <= arm_cnt + 1'b1;
            prev_q <= pin_val;
            // Set has priority over a same-cycle write-1-to-clear.
            stat_q <= (stat_q & ~w1c) | evt;
            irq_q  <= |(stat_q & ie_q);
            ack_q  <= access;
            dat_q  <= (access && !wb_we_i) ? rdata : '0;
            if (wr_en) begin
                case (addr)
                    ADR_OUT:  out_q  <= wr_data;
                    ADR_DIR:  dir_q  <= wr_data;
                    ADR_IE:   ie_q   <= wr_data;
                    ADR_EDGE: edge_q <= wr_data;
                    default:  ;
                endcase
            end
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign gpio_o   = out_q;
    assign gpio_oe  = dir_q;
    assign irq_o    = irq_q;

endmodule
